mips_fetch: RTL and testbench
=============================

// Module: mips_fetch
// PURPOSE
//  Instruction-fetch stage feeding the MIPS controller/datapath: owns the PC, issues word reads to
//  instruction memory, and holds the fetched instruction. op=instr[31:26] and funct=instr[5:0] go to
//  the controller. The controller's pcsrc/jump come back here to select the next PC.
//  Handles variable-latency memory (req/ack) and downstream backpressure (valid/ready).
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address; bits [1:0] forced to 0
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  reset        in   1   synchronous, active-low (0 = reset)
//  imem_req     out  1   read request, high only in FETCH
//  imem_addr    out  32  word-aligned read address (= pc)
//  imem_ack     in   1   1-cycle pulse, imem_rdata valid this cycle
//  imem_rdata   in   32  instruction word
//  instr        out  32  held instruction
//  pc           out  32  address of instr / current fetch
//  pc_plus4     out  32  pc + 4 (datapath uses for link/branch)
//  instr_valid  out  1   instr is valid for downstream
//  instr_ready  in   1   downstream consumes instr this cycle
//  pcsrc        in   1   from controller (branch & zero), qualifies the held instr
//  jump         in   1   from controller, qualifies the held instr
// BEHAVIOUR
//  - Reset (reset==0 at an edge): state=IDLE, pc=RESET_PC, instr=0; imem_req=0, instr_valid=0.
//  - FSM IDLE -> FETCH (unconditional, 1 cycle). FETCH: imem_req=1, imem_addr=pc.
//    On imem_ack: instr<=imem_rdata, -> VALID. VALID: instr_valid=1, imem_req=0.
//    On instr_ready: pc<=next_pc, -> FETCH.
//  - Latency: ack in the same cycle as req is legal (zero-wait). instr_valid rises the cycle after ack.
//    Peak throughput is 1 instr / 2 cycles.
//  - next_pc priority: jump -> {pc_plus4[31:28], instr[25:0], 2'b00}.
//    Else pcsrc -> pc_plus4 + {signext(instr[15:0]), 2'b00}. Else pc_plus4.
//    pcsrc and jump are sampled only in the VALID & instr_ready cycle; ignored otherwise.
//  - Arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0. pc[1:0] is always 00.
//  - imem_ack outside FETCH is ignored. imem_addr is stable for the whole FETCH wait.
//  - instr and pc are stable while instr_valid & !instr_ready.
//  - Reset mid-operation (any state) abandons the request. An ack arriving in the reset cycle is dropped.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//   - Adds outputs perf_fetched[31:0] (+1 per VALID & instr_ready) and perf_stall[31:0] (+1 per FETCH
//     cycle without ack).
//   - Both counters clear to 0 on reset and wrap modulo 2^32.
//  FETCH_PERF_EN undefined: ports and counters absent; all other behaviour is identical.
// STRUCTURE
//  - mips_pkg: fetch state enum (IDLE/FETCH/VALID), opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
//    OP_ADDI, OP_J), default RESET_PC.
//  - Sub-module mips_next_pc (combinational): pc_plus4, instr, pcsrc, jump -> next_pc.
//  - FSM, PC register and instr register stay in mips_fetch.
// TESTING
//  1 Reset:
//    reset=0 for 2 cycles -> imem_req=0, instr_valid=0, pc=0.
//    Release -> IDLE 1 cycle, then imem_req=1, imem_addr=0.
//  2 Sequential zero-wait:
//    ack with req, instr_ready=1, pcsrc=jump=0 -> addresses 0,4,8,C, one every 2 cycles.
//  3 Branch/jump:
//    - pc=0x10, instr=0x1000FFFF, pcsrc=1 -> next addr 0x10.
//    - pc=0, instr=0x08000040, jump=1 -> 0x100.
//    - pcsrc=jump=1 -> jump target wins.
//  4 Wait states:
//    ack delayed 3 cycles -> req/addr held at 0x8, instr_valid=0.
//    ack with rdata=0x20080005 -> instr_valid=1 next cycle, instr=0x20080005.
//  5 Backpressure/reset:
//    instr_ready=0 for 5 cycles -> instr, pc stable, imem_req=0.
//    reset=0 during FETCH wait -> late ack dropped; restart at RESET_PC.
//  6 Wrap/perf:
//    RESET_PC=32'hFFFF_FFFC, sequential -> second addr 0.
//    With FETCH_PERF_EN: 3 retires + 2 wait cycles -> perf_fetched=3, perf_stall=2.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage: fetch FSM states,
// primary opcode values and the default reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/mips_next_pc.sv
// Next-PC select for the fetch stage: jump beats branch beats sequential.
// Purely combinational; only the low 26 instruction bits are needed.
module mips_next_pc (
    input  logic [31:0] pc_plus4_i,
    input  logic [25:0] instr_idx_i,
    input  logic        pcsrc_i,
    input  logic        jump_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] branch_off;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;

    assign branch_off = {{14{instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};
    assign branch_tgt = pc_plus4_i + branch_off;
    assign jump_tgt   = {pc_plus4_i[31:28], instr_idx_i, 2'b00};

    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jump_i) begin
            next_pc_o = jump_tgt;
        end else if (pcsrc_i) begin
            next_pc_o = branch_tgt;
        end
    end

endmodule

// File: rtl/mips_fetch.sv
// MIPS instruction-fetch stage: PC register, req/ack imem read, held instruction with valid/ready.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | one-cycle settle after reset, no request
// ST_FETCH | imem_req high at pc, waiting for imem_ack
// ST_VALID | instr held and offered downstream
module mips_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pcsrc,
    input  logic        jump
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  next_pc;
    logic         retire;

    assign pc_plus4  = pc_q + 32'd4;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;

    mips_next_pc u_next_pc (
        .pc_plus4_i  (pc_plus4),
        .instr_idx_i (instr_q[25:0]),
        .pcsrc_i     (pcsrc),
        .jump_i      (jump),
        .next_pc_o   (next_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        retire      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    retire  = 1'b1;
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_INIT;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            if (retire) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (imem_req && !imem_ack) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mips_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_ready = 1'b0;
    logic        pcsrc = 1'b0;
    logic        jump = 1'b0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4;

    logic        w_reset = 1'b0;
    logic        w_ack = 1'b1;
    logic        w_ready = 1'b1;
    logic        w_zero = 1'b0;
    logic [31:0] w_rdata = 32'd0;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc_plus4;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

    mips_fetch dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .pc(pc),
        .pc_plus4(pc_plus4), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pcsrc(pcsrc), .jump(jump)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    mips_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(w_reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .instr(w_instr), .pc(w_pc),
        .pc_plus4(w_pc_plus4), .instr_valid(w_valid), .instr_ready(w_ready),
        .pcsrc(w_zero), .jump(w_zero)
`ifdef FETCH_PERF_EN
        , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
`endif
    );

    // Reference model: "waiting" = post-reset settle cycle, "holding" = instruction offered.
    bit          m_settle = 1'b1;
    bit          m_holding = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_fetched = 32'd0;
    logic [31:0] m_stall = 32'd0;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] target(input logic [31:0] cur_pc, input logic [31:0] ins,
                                           input logic ps, input logic jp);
        logic [31:0] seq;
        int          off;
        seq = cur_pc + 32'd4;
        off = int'($signed(ins[15:0])) * 4;
        if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (ps) return seq + 32'(off);
        return seq;
    endfunction

    task automatic compare_all();
        chk("imem_req",    {31'd0, imem_req},    {31'd0, !m_settle && !m_holding});
        chk("imem_addr",   imem_addr,            m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
        chk("instr",       instr,                m_instr);
        chk("pc",          pc,                   m_pc);
        chk("pc_plus4",    pc_plus4,             m_pc + 32'd4);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stall",   perf_stall,   m_stall);
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic rn, input logic ack, input logic [31:0] rd,
                        input logic rdy, input logic ps, input logic jp);
        bit          n_settle, n_holding;
        logic [31:0] n_pc, n_instr, n_fetched, n_stall;
        reset = rn; imem_ack = ack; imem_rdata = rd;
        instr_ready = rdy; pcsrc = ps; jump = jp;
        #1;
        if (imem_req && imem_ack && reset) begin
            acc_addr.push_back(imem_addr);
            acc_cyc.push_back(cyc);
        end
        n_settle = m_settle; n_holding = m_holding; n_pc = m_pc; n_instr = m_instr;
        n_fetched = m_fetched; n_stall = m_stall;
        if (!rn) begin
            n_settle = 1'b1; n_holding = 1'b0; n_pc = 32'd0; n_instr = 32'd0;
            n_fetched = 32'd0; n_stall = 32'd0;
        end else if (m_settle) begin
            n_settle = 1'b0;
        end else if (!m_holding) begin
            if (ack) begin
                n_instr = rd; n_holding = 1'b1;
            end else begin
                n_stall = m_stall + 32'd1;
            end
        end else if (rdy) begin
            n_pc = target(m_pc, m_instr, ps, jp);
            n_holding = 1'b0;
            n_fetched = m_fetched + 32'd1;
        end
        @(posedge clk);
        m_settle = n_settle; m_holding = n_holding; m_pc = n_pc; m_instr = n_instr;
        m_fetched = n_fetched; m_stall = n_stall;
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [31:0] hold_instr, hold_pc;
        @(negedge clk);

        // 1: reset and release
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 32'hFFFF_FFFF, 1, 1, 1);
        chk("t1_req_rst",   {31'd0, imem_req},    32'd0);
        chk("t1_valid_rst", {31'd0, instr_valid}, 32'd0);
        chk("t1_pc_rst",    pc,                   32'd0);
        step(1, 0, 0, 0, 0, 0);
        chk("t1_req_fetch", {31'd0, imem_req}, 32'd1);
        chk("t1_addr0",     imem_addr,         32'd0);

        // 2: sequential zero-wait
        acc_addr.delete(); acc_cyc.delete();
        for (int i = 0; i < 8; i++) step(1, 1, 32'h0000_0000, 1, 0, 0);
        chk("t2_count", 32'(acc_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
            chk("t2_addr", acc_addr[i], 32'(i * 4));
            if (i > 0) chk("t2_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        end

        // 3: branch, jump, jump-over-branch
        chk("t3_at_10", imem_addr, 32'h10);
        step(1, 1, 32'h1000_FFFF, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0);
        chk("t3_branch", imem_addr, 32'h10);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32'h0800_0040, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1);
        chk("t3_jump", imem_addr, 32'h100);
        step(1, 1, 32'h0800_0040, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1);
        chk("t3_jump_wins", imem_addr, 32'h100);

        // 4: wait states at 0x8
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'hBAD0_0000, 1, 0, 0);
            chk("t4_req_held",  {31'd0, imem_req},    32'd1);
            chk("t4_addr_held", imem_addr,            32'h8);
            chk("t4_not_valid", {31'd0, instr_valid}, 32'd0);
        end
        step(1, 1, 32'h2008_0005, 0, 0, 0);
        chk("t4_valid", {31'd0, instr_valid}, 32'd1);
        chk("t4_instr", instr,                32'h2008_0005);

        // 5: backpressure, then reset during a fetch wait
        hold_instr = instr; hold_pc = pc;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h1111_1111, 0, 1, 1);
            chk("t5_instr_stable", instr,              hold_instr);
            chk("t5_pc_stable",    pc,                 hold_pc);
            chk("t5_no_req",       {31'd0, imem_req},  32'd0);
        end
        step(1, 0, 0, 1, 0, 0);
        chk("t5_next_c", imem_addr, 32'hC);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("t5_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_rst_instr", instr,                32'd0);
        step(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("t5_idle_ack_ignored", {31'd0, instr_valid}, 32'd0);
        chk("t5_restart_addr",     imem_addr,            32'd0);

`ifdef FETCH_PERF_EN
        // perf counters: 2 stall cycles, 3 retires
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0);
            step(1, 0, 0, 1, 0, 0);
        end
        chk("t6_perf_fetched", perf_fetched, 32'd3);
        chk("t6_perf_stall",   perf_stall,   32'd2);
`endif

        // 6: wrap from RESET_PC = FFFF_FFFC
        w_reset = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        chk("t6_wrap_req",   {31'd0, w_req}, 32'd1);
        chk("t6_wrap_addr0", w_addr,         32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 0);
        chk("t6_wrap_valid", {31'd0, w_valid}, 32'd1);
        chk("t6_wrap_plus4", w_pc_plus4,       32'd0);
        step(1, 0, 0, 0, 0, 0);
        chk("t6_wrap_addr1", w_addr,           32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) >= 2,
                 $urandom_range(0, 99) < 40,
                 $urandom,
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 25);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
